seq_alu: RTL and testbench
==========================

# seq_alu

Parametrised sequential ALU for the RISC-V datapath. It replaces the 3-bit-control combinational ALU with a `WIDTH`-bit unit that extends the operation set with shifts, signed/unsigned compares and an iterative shift-add multiplier. Results are registered. A start/busy/done handshake lets the control unit stall on multi-cycle operations.

## Interface
- `WIDTH`, 32: operand/result width; power of two, ≥ 8. `SHW = $clog2(WIDTH)`.
- `clk`  in  1  clock; all state changes on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `start`  in  1  request; accepted only when `busy`=0.
- `srcA`  in  WIDTH  operand A; sampled at acceptance.
- `srcB`  in  WIDTH  operand B; sampled at acceptance.
- `ALUControl`  in  4  operation select; sampled at acceptance.
- `res`  out  WIDTH  registered result; holds until the next completion.
- `zero`  out  1  `res == 0`, derived from the `res` register.
- `busy`  out  1  multi-cycle operation in progress.
- `done`  out  1  high for exactly one cycle per completed operation.

## Operation
- Opcodes:
  - 0000 add
  - 0001 sub
  - 0010 and
  - 0011 or
  - 0100 xor
  - 0101 slt: signed, result 1/0, zero-extended
  - 0110 sltu
  - 0111 sll
  - 1000 srl
  - 1001 sra
  - 1010 mul: low WIDTH bits of the unsigned product
  - 1011 mulhu: high WIDTH bits of the unsigned 2·WIDTH product
  - 1100–1111: reserved; result 0, completes like a single-cycle op.
- Add and sub wrap modulo 2^WIDTH; there is no carry or overflow output.
- Shift amount is `srcB[SHW-1:0]`; upper bits of `srcB` are ignored.
- States:
  - IDLE
  - MUL
- In IDLE, `start`=1 with a single-cycle opcode: compute, write `res`, set `done`=1, remain in IDLE.
- In IDLE, `start`=1 with mul/mulhu: latch operands and opcode, clear the 2·WIDTH accumulator, set iteration counter to 0, set `busy`=1, go to MUL.
- MUL performs one iteration per cycle: if the current multiplier bit is 1, add the shifted multiplicand to the accumulator; shift; increment the counter.
- When the counter reaches WIDTH-1 in MUL, on that edge:
  - write the selected half of the accumulator to `res`;
  - `done`=1, `busy`=0;
  - return to IDLE.
- `done` is cleared on every edge that does not complete an operation.
- `start` while `busy`=1 is ignored and not queued. Changes on `srcA`, `srcB` or `ALUControl` during MUL have no effect.

## Timing
- Reset (`rst_n`=0 at an edge) forces `res`=0, `zero`=1, `done`=0, `busy`=0, state IDLE, counter 0. This overrides `start`.
- Reset mid-MUL aborts the operation; no `done` is produced.
- Acceptance edge e0 = first edge with `start`=1, `busy`=0, `rst_n`=1.
- Single-cycle op: `res` and `done` are valid after e0, so latency is 1 cycle. Issue rate is one op per cycle; `done` stays high across back-to-back starts.
- mul/mulhu: `busy` is high after e0, and iterations occur on edges e1..eW.
  - After edge eW: `res` is valid, `done`=1, `busy`=0. Latency is WIDTH cycles after acceptance; `busy` is high for exactly WIDTH cycles.
  - A `start` sampled at edge eW is ignored, because `busy`=1 during the preceding cycle.
  - The next request can be accepted at eW+1, while `done` is high.
- `zero` tracks `res` with no extra delay.

## Test plan
- Reset: hold `rst_n`=0 for 2 cycles with `start`=1 and `ALUControl`=0000 -> `res`=0, `zero`=1, `done`=0, `busy`=0.
- Back-to-back basics: `srcA`=0xFF, `srcB`=0x0F, one start per cycle with add, sub, and, or, xor -> `res` = 0x10E, 0xF0, 0x0F, 0xFF, 0xF0 on consecutive cycles. `done` is high for 5 consecutive cycles.
- Compare and shift:
  - `srcA`=0xFFFFFFFF, `srcB`=1 -> slt 1, sltu 0.
  - `srcA`=0x80000000, `srcB`=4 -> sra 0xF8000000, srl 0x08000000.
  - `srcA`=1, `srcB`=0x24 -> sll 0x10 (only the low 5 bits used).
- Multiply:
  - 0xFF × 0x0F with mul -> `res`=0xEF1. `done` pulses exactly 32 cycles after acceptance; `busy` is high 32 cycles.
  - 0xFFFFFFFF × 0xFFFFFFFF: mul -> 0x00000001, mulhu -> 0xFFFFFFFE.
- Protection:
  - During mul, pulse `start` with add and change the operands -> ignored; the mul result is unchanged.
  - `rst_n`=0 at iteration 10 -> outputs return to reset values and no `done` pulse follows. A subsequent add of 2+3 gives 5 after 1 cycle.
- Zero and reserved: sub 5−5 -> `res`=0, `zero`=1. `ALUControl`=1111 -> `res`=0 with a single `done` pulse.

Source files
------------

// File: rtl/seq_alu_if.sv
// Bus between the control unit and seq_alu: request operands/opcode in,
// registered result and start/busy/done status out.
interface seq_alu_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] srcA;
  logic [WIDTH-1:0] srcB;
  logic [3:0]       ALUControl;
  logic [WIDTH-1:0] res;
  logic             zero;
  logic             busy;
  logic             done;

  modport master (
    output start, srcA, srcB, ALUControl,
    input  res, zero, busy, done
  );

  modport slave (
    input  start, srcA, srcB, ALUControl,
    output res, zero, busy, done
  );
endinterface

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle arithmetic/logic/shift/compare ops plus an
// iterative shift-add multiplier (mul / mulhu) taking WIDTH cycles.
module seq_alu #(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  seq_alu_if.slave   bus,
  output logic       dbg_state
);
  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

  // Handshake: a request is taken on any edge with start=1 and busy=0;
  // done pulses for one cycle on the edge that writes res; start while
  // busy=1 is dropped, never queued.
  typedef enum logic {IDLE = 1'b0, MUL = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [SHW-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic               hi_q, hi_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               done_q, done_d;

  logic [2*WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0]   single_res;
  logic [SHW-1:0]     shamt;
  logic               is_mul;

  assign shamt  = bus.srcB[SHW-1:0];
  assign is_mul = (bus.ALUControl == 4'b1010) || (bus.ALUControl == 4'b1011);

  always_comb begin
    single_res = '0;
    case (bus.ALUControl)
      4'b0000: single_res = bus.srcA + bus.srcB;
      4'b0001: single_res = bus.srcA - bus.srcB;
      4'b0010: single_res = bus.srcA & bus.srcB;
      4'b0011: single_res = bus.srcA | bus.srcB;
      4'b0100: single_res = bus.srcA ^ bus.srcB;
      4'b0101: single_res = {{(WIDTH-1){1'b0}}, $signed(bus.srcA) < $signed(bus.srcB)};
      4'b0110: single_res = {{(WIDTH-1){1'b0}}, bus.srcA < bus.srcB};
      4'b0111: single_res = bus.srcA << shamt;
      4'b1000: single_res = bus.srcA >> shamt;
      4'b1001: single_res = $unsigned($signed(bus.srcA) >>> shamt);
      default: single_res = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    hi_d     = hi_q;
    res_d    = res_q;
    done_d   = 1'b0;
    acc_nxt  = acc_q + (mplier_q[0] ? mcand_q : '0);

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (is_mul) begin
            mcand_d  = {{WIDTH{1'b0}}, bus.srcA};
            mplier_d = bus.srcB;
            acc_d    = '0;
            cnt_d    = '0;
            hi_d     = bus.ALUControl[0];
            state_d  = MUL;
          end else begin
            res_d  = single_res;
            done_d = 1'b1;
          end
        end
      end
      MUL: begin
        // Multiplicand walks left while the multiplier bit under test walks right.
        acc_d    = acc_nxt;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          res_d   = hi_q ? acc_nxt[2*WIDTH-1:WIDTH] : acc_nxt[WIDTH-1:0];
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      hi_q     <= 1'b0;
      res_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      hi_q     <= hi_d;
      res_q    <= res_d;
      done_q   <= done_d;
    end
  end

  assign bus.res   = res_q;
  assign bus.zero  = (res_q == '0);
  assign bus.busy  = (state_q == MUL);
  assign bus.done  = done_q;
  assign dbg_state = state_q;
endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu: directed vector table, multi-cycle corner sequences and
// random operations checked against an arithmetic reference model.
module tb_seq_alu;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n;
  logic dbg_state;

  seq_alu_if #(.WIDTH(W)) bus ();

  seq_alu #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
  } vec_t;

  vec_t vecs[$];
  logic [W-1:0] exp_q[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_model(input logic [3:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
    logic [2*W-1:0] prod;
    int sh;
    longint sa;
    prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    sh   = int'(b % W);
    sa   = longint'($signed(a));
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return ($signed(a) < $signed(b)) ? 1 : 0;
      4'd6:  return (a < b) ? 1 : 0;
      4'd7:  return a << sh;
      4'd8:  return a >> sh;
      4'd9:  return W'(sa / (longint'(1) << sh) - ((sa < 0 && (sa % (longint'(1) << sh)) != 0) ? 1 : 0));
      4'd10: return prod[W-1:0];
      4'd11: return prod[2*W-1:W];
      default: return '0;
    endcase
  endfunction

  task automatic do_mul(input string name, input logic [3:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp, input bit prot);
    int n;
    int busy_cycles;
    bus.start = 1'b1; bus.ALUControl = op; bus.srcA = a; bus.srcB = b;
    tick();
    bus.start = 1'b0;
    check({name, "_busy_e0"}, bus.busy, 1);
    check({name, "_done_e0"}, bus.done, 0);
    n = 0;
    busy_cycles = 0;
    while (n < 100 && !bus.done) begin
      if (bus.busy) busy_cycles++;
      if (prot && n >= 4) begin
        bus.start = 1'b1; bus.ALUControl = 4'b0000;
        bus.srcA = $urandom; bus.srcB = $urandom;
      end
      tick();
      n++;
    end
    bus.start = 1'b0;
    check({name, "_latency"}, n, W);
    check({name, "_busy_cycles"}, busy_cycles, W);
    check({name, "_res"}, bus.res, exp);
    check({name, "_busy_end"}, bus.busy, 0);
    check({name, "_zero"}, bus.zero, (exp == '0));
    tick();
    check({name, "_done_drop"}, bus.done, 0);
    check({name, "_res_hold"}, bus.res, exp);
  endtask

  initial begin
    int done_seen;
    logic [3:0] op;
    logic [W-1:0] a, b;

    bus.start = 1'b0; bus.srcA = '0; bus.srcB = '0; bus.ALUControl = '0;
    rst_n = 1'b0;

    // Reset overrides a pending start.
    bus.start = 1'b1; bus.srcA = 32'd1; bus.srcB = 32'd2;
    tick(); tick();
    check("rst_res", bus.res, 0);
    check("rst_zero", bus.zero, 1);
    check("rst_done", bus.done, 0);
    check("rst_busy", bus.busy, 0);
    bus.start = 1'b0;
    rst_n = 1'b1;
    tick();

    vecs.push_back('{4'b0000, 32'hFF, 32'h0F, 32'h10E});
    vecs.push_back('{4'b0001, 32'hFF, 32'h0F, 32'hF0});
    vecs.push_back('{4'b0010, 32'hFF, 32'h0F, 32'h0F});
    vecs.push_back('{4'b0011, 32'hFF, 32'h0F, 32'hFF});
    vecs.push_back('{4'b0100, 32'hFF, 32'h0F, 32'hF0});
    vecs.push_back('{4'b0101, 32'hFFFFFFFF, 32'd1, 32'd1});
    vecs.push_back('{4'b0110, 32'hFFFFFFFF, 32'd1, 32'd0});
    vecs.push_back('{4'b1001, 32'h80000000, 32'd4, 32'hF8000000});
    vecs.push_back('{4'b1000, 32'h80000000, 32'd4, 32'h08000000});
    vecs.push_back('{4'b0111, 32'd1, 32'h24, 32'h10});
    vecs.push_back('{4'b0001, 32'd5, 32'd5, 32'd0});
    vecs.push_back('{4'b1111, 32'h1234, 32'h5678, 32'd0});

    // Back-to-back issue: done stays high every cycle.
    foreach (vecs[i]) begin
      bus.start = 1'b1; bus.ALUControl = vecs[i].op;
      bus.srcA = vecs[i].a; bus.srcB = vecs[i].b;
      tick();
      check($sformatf("vec%0d_res", i), bus.res, vecs[i].exp);
      check($sformatf("vec%0d_done", i), bus.done, 1);
      check($sformatf("vec%0d_zero", i), bus.zero, (vecs[i].exp == '0));
    end
    bus.start = 1'b0;
    tick();
    check("reserved_single_done", bus.done, 0);

    do_mul("mul_ff_0f", 4'b1010, 32'hFF, 32'h0F, 32'hEF1, 1'b0);
    do_mul("mul_max", 4'b1010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1, 1'b0);
    do_mul("mulhu_max", 4'b1011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0);
    do_mul("mul_prot", 4'b1010, 32'h1234, 32'h5678, 32'h06260060, 1'b1);

    // Reset on iteration edge 10 aborts the multiply silently.
    bus.start = 1'b1; bus.ALUControl = 4'b1010; bus.srcA = 32'h77; bus.srcB = 32'h99;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("abort_res", bus.res, 0);
    check("abort_zero", bus.zero, 1);
    check("abort_busy", bus.busy, 0);
    check("abort_done", bus.done, 0);
    done_seen = 0;
    for (int i = 0; i < W + 5; i++) begin
      tick();
      if (bus.done) done_seen++;
    end
    check("abort_no_done", done_seen, 0);
    bus.start = 1'b1; bus.ALUControl = 4'b0000; bus.srcA = 32'd2; bus.srcB = 32'd3;
    tick();
    bus.start = 1'b0;
    check("after_abort_res", bus.res, 5);
    check("after_abort_done", bus.done, 1);
    tick();

    // Random ops against the reference model.
    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 70)) : W'($urandom);
      if ($urandom_range(0, 7) == 0) b = a;
      exp_q.push_back(ref_model(op, a, b));
      if (op == 4'd10 || op == 4'd11) begin
        do_mul($sformatf("rnd%0d_mul", i), op, a, b, exp_q.pop_front(), 1'b0);
      end else begin
        bus.start = 1'b1; bus.ALUControl = op; bus.srcA = a; bus.srcB = b;
        tick();
        bus.start = 1'b0;
        check($sformatf("rnd%0d_op%0d_res", i, op), bus.res, exp_q.pop_front());
        check($sformatf("rnd%0d_done", i), bus.done, 1);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
